// File: rtl/sram_arbiter.sv
// Arbitrates camera writes and USB reads onto one asynchronous SRAM; all strobes are registered.
// Define SRAM_ARB_RR_EN for alternating grants on simultaneous requests (default: camera has priority).
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk_fast,
  input  logic              reset_n,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_ack,
  input  logic              usb_req,
  input  logic [ADDR_W-1:0] usb_addr,
  output logic [DATA_W-1:0] usb_rdata,
  output logic              usb_rd_valid,
  output logic [ADDR_W-1:0] ad,
  inout  wire  [DATA_W-1:0] dio_a,
  output logic              we_n,
  output logic              oe_n,
  output logic              ce_a_n,
  output logic              ub_a_n,
  output logic              lb_a_n,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_PULSE, WR_END, RD_WAIT, RD_CAP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              usb_req_eff, grant_cam, grant_usb;
  logic              ce_n_d, we_n_d, oe_n_d, dio_oe_d, ack_d, valid_d, busy_d;
  logic              ce_n_q, we_n_q, oe_n_q, dio_oe_q, ack_q, valid_q, busy_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  // A USB request still high in its own valid cycle belongs to the finished read.
  assign usb_req_eff = usb_req && !valid_q;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;  // 1 = USB was granted last

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == IDLE && (grant_cam || grant_usb)) begin
      last_grant_q <= grant_usb;
    end
  end

  assign grant_cam = cam_req && (!usb_req_eff || last_grant_q);
`else
  assign grant_cam = cam_req;
`endif
  assign grant_usb = usb_req_eff && !grant_cam;

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_cam) begin
          state_d = WR_ADDR;
        end else if (grant_usb) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WR_ADDR: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_INIT;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = WR_END;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_END:  state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == 4'd0) state_d = RD_CAP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    ce_n_d   = (state_d == IDLE);
    we_n_d   = (state_d != WR_PULSE);
    oe_n_d   = !(state_d == RD_WAIT || state_d == RD_CAP);
    dio_oe_d = (state_d == WR_ADDR || state_d == WR_PULSE || state_d == WR_END);
    ack_d    = (state_d == WR_END);
    valid_d  = (state_q == RD_CAP);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dio_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dio_oe_q <= dio_oe_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      ad_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant_cam) begin
        ad_q    <= cam_addr;
        wdata_q <= cam_wdata;
      end else if (state_q == IDLE && grant_usb) begin
        ad_q    <= usb_addr;
      end
      if (state_q == RD_CAP) rdata_q <= dio_a;
    end
  end

  assign dio_a        = dio_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign ad           = ad_q;
  assign ce_a_n       = ce_n_q;
  assign ub_a_n       = ce_n_q;
  assign lb_a_n       = ce_n_q;
  assign we_n         = we_n_q;
  assign oe_n         = oe_n_q;
  assign cam_ack      = ack_q;
  assign usb_rd_valid = valid_q;
  assign usb_rdata    = rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on dio_a, scoreboard queues for read data and grant order.
module tb_sram_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int WAIT   = 2;

  logic              clk_fast, reset_n;
  logic              cam_req, usb_req;
  logic [ADDR_W-1:0] cam_addr, usb_addr, ad;
  logic [DATA_W-1:0] cam_wdata, usb_rdata;
  logic              cam_ack, usb_rd_valid, we_n, oe_n, ce_a_n, ub_a_n, lb_a_n, busy;
  wire  [DATA_W-1:0] dio_a;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] sram [256];
  logic [DATA_W-1:0] sb_mem [256];
  logic [DATA_W-1:0] exp_rd_q [$];
  logic [31:0]       exp_grant_q [$];
  logic [DATA_W-1:0] last_wd;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT)) dut (
    .clk_fast(clk_fast), .reset_n(reset_n),
    .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_ack(cam_ack),
    .usb_req(usb_req), .usb_addr(usb_addr), .usb_rdata(usb_rdata), .usb_rd_valid(usb_rd_valid),
    .ad(ad), .dio_a(dio_a), .we_n(we_n), .oe_n(oe_n), .ce_a_n(ce_a_n),
    .ub_a_n(ub_a_n), .lb_a_n(lb_a_n), .busy(busy)
  );

  // Asynchronous SRAM model (low address byte only).
  assign dio_a = (!ce_a_n && !oe_n && we_n) ? sram[ad[7:0]] : {DATA_W{1'bz}};
  always @(posedge clk_fast) if (!ce_a_n && !we_n) sram[ad[7:0]] <= dio_a;

  initial begin
    clk_fast = 1'b0;
    forever #5 clk_fast = ~clk_fast;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    do begin
      @(negedge clk_fast);
      n++;
    end while (!busy && n < 30);
    check({tag, "_grant"}, 32'(busy), 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input bit chain, input logic [ADDR_W-1:0] ra);
    int cyc, we_cnt;
    @(negedge clk_fast);
    cam_addr = a; cam_wdata = d; cam_req = 1'b1;
    wait_busy("wr");
    check("wr_ad", 32'(ad), 32'(a));
    check("wr_dio", 32'(dio_a), 32'(d));
    check("wr_strobes", {28'd0, we_n, ce_a_n, ub_a_n, lb_a_n}, 32'b1000);
    cyc = 1; we_cnt = 0;
    while (!cam_ack && cyc < 20) begin
      @(negedge clk_fast);
      cyc++;
      if (!we_n) we_cnt++;
    end
    check("wr_lat", 32'(cyc), 32'(WAIT + 2));
    check("wr_we_cnt", 32'(we_cnt), 32'(WAIT));
    check("wr_dio_end", 32'(dio_a), 32'(d));
    sb_mem[a[7:0]] = d;
    last_wd = d;
    cam_req = 1'b0;
    if (chain) begin
      usb_addr = ra; usb_req = 1'b1;
    end else begin
      @(negedge clk_fast);
      check("wr_ack_pulse", 32'(cam_ack), 32'd0);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input bit pre);
    int n = 0;
    int gap = 0;
    int cyc;
    exp_rd_q.push_back(sb_mem[a[7:0]]);
    if (!pre) begin
      @(negedge clk_fast);
      usb_addr = a; usb_req = 1'b1;
    end
    do begin
      @(negedge clk_fast);
      n++;
      if (!busy && oe_n && we_n && dio_a !== last_wd) gap++;
    end while (!busy && n < 30);
    check("rd_grant", 32'(busy), 32'd1);
    if (pre) check("rd_gap", 32'(gap >= 1), 32'd1);
    check("rd_ad", 32'(ad), 32'(a));
    check("rd_strobes", {28'd0, we_n, oe_n, ce_a_n, lb_a_n}, 32'b1000);
    cyc = 1;
    while (!usb_rd_valid && cyc < 20) begin
      @(negedge clk_fast);
      cyc++;
    end
    check("rd_lat", 32'(cyc), 32'(WAIT + 2));
    check("rd_data", 32'(usb_rdata), 32'(exp_rd_q.pop_front()));
    usb_req = 1'b0;
    @(negedge clk_fast);
    check("rd_valid_pulse", 32'(usb_rd_valid), 32'd0);
  endtask

  task automatic arb_test();
    int n = 0;
    logic prev_busy = 1'b0;
`ifdef SRAM_ARB_RR_EN
    exp_grant_q = '{32'd0, 32'd1, 32'd0};
`else
    exp_grant_q = '{32'd0, 32'd0, 32'd0};
`endif
    @(negedge clk_fast);
    cam_addr = 20'h00077; cam_wdata = 16'h1111; cam_req = 1'b1;
    usb_addr = 20'h00078; usb_req = 1'b1;
    while (exp_grant_q.size() > 0 && n < 80) begin
      @(negedge clk_fast);
      n++;
      // 0 = camera (write, oe_n high), 1 = USB (read, oe_n low)
      if (busy && !prev_busy) check("arb_grant", 32'(!oe_n), exp_grant_q.pop_front());
      prev_busy = busy;
    end
    check("arb_all_grants", 32'(exp_grant_q.size()), 32'd0);
    cam_req = 1'b0; usb_req = 1'b0;
    sb_mem[8'h77] = 16'h1111;
    repeat (12) @(negedge clk_fast);
    check("arb_drained", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cam_req = 1'b0; usb_req = 1'b0;
    cam_addr = '0; cam_wdata = '0; usb_addr = '0; last_wd = '0;
    repeat (2) @(negedge clk_fast);
    check("rst_strobes", {27'd0, ce_a_n, we_n, oe_n, ub_a_n, lb_a_n}, 32'h1f);
    check("rst_ad", 32'(ad), 32'd0);
    check("rst_ack", 32'(cam_ack), 32'd0);
    check("rst_valid", 32'(usb_rd_valid), 32'd0);
    check("rst_rdata", 32'(usb_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    do_write(20'h12345, 16'hA5A5, 1'b0, '0);
    do_read(20'h12345, 1'b0);
    do_write(20'h00101, 16'h3C3C, 1'b1, 20'h00101);
    do_read(20'h00101, 1'b1);
    do_write(20'hFFFFF, 16'h0001, 1'b0, '0);
    do_read(20'h12345, 1'b0);
    do_read(20'hFFFFF, 1'b0);

    arb_test();

    @(negedge clk_fast);
    cam_addr = 20'h00ABC; cam_wdata = 16'h5A3C; cam_req = 1'b1;
    wait_busy("rst_mid");
    @(negedge clk_fast);
    check("rst_mid_pulse", 32'(we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(we_n), 32'd1);
    check("rst_mid_ce", 32'(ce_a_n), 32'd1);
    check("rst_mid_dio", 32'(dio_a !== 16'h5A3C), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    cam_req = 1'b0;
    repeat (2) begin
      @(negedge clk_fast);
      check("rst_mid_no_ack", 32'(cam_ack), 32'd0);
    end
    reset_n = 1'b1;
    do_write(20'h00ABC, 16'h5A3C, 1'b0, '0);
    do_read(20'h00ABC, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning SRAM data width.
REQ-003 The block SHALL have parameter WAIT_CYC, default 2, meaning SRAM access cycles per strobe; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_fast  in  1  meaning system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n  in  1  meaning asynchronous active-low reset.
REQ-007 The block SHALL have port cam_req  in  1  meaning camera-side write request, level, held until cam_ack.
REQ-008 The block SHALL have port cam_addr  in  ADDR_W  meaning camera write address, stable while cam_req is high.
REQ-009 The block SHALL have port cam_wdata  in  DATA_W  meaning camera write data, stable while cam_req is high.
REQ-010 The block SHALL have port cam_ack  out  1  meaning one-cycle pulse when the write has completed.
REQ-011 The block SHALL have port usb_req  in  1  meaning USB-side read request, level, held until usb_rd_valid.
REQ-012 The block SHALL have port usb_addr  in  ADDR_W  meaning read address, stable while usb_req is high.
REQ-013 The block SHALL have port usb_rdata  out  DATA_W  meaning read data, registered, valid when usb_rd_valid is high.
REQ-014 The block SHALL have port usb_rd_valid  out  1  meaning one-cycle pulse; usb_rdata is valid in the same cycle.
REQ-015 The block SHALL have port ad  out  ADDR_W  meaning SRAM address.
REQ-016 The block SHALL have port dio_a  inout  DATA_W  meaning SRAM data bus.
REQ-017 The block SHALL have ports we_n, oe_n, ce_a_n, ub_a_n, lb_a_n  out  1 each  meaning SRAM strobes, all active-low and all registered.
REQ-018 The block SHALL have port busy  out  1  meaning high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, WR_ADDR, WR_PULSE, WR_END, RD_WAIT and RD_CAP.
REQ-020 In IDLE, the block SHALL sample cam_req and usb_req, and on a grant SHALL register the winner's address (and write data for a write) in the same edge.
REQ-021 In IDLE, the block SHALL hold ce_a_n, we_n, oe_n, ub_a_n and lb_a_n at 1 and SHALL tristate dio_a.
REQ-022 The write sequence SHALL be: WR_ADDR for 1 cycle (ce_a_n=0, ub/lb=0, dio_a driven, we_n=1), then WR_PULSE for exactly WAIT_CYC cycles (we_n=0), then WR_END for 1 cycle (we_n=1, dio_a still driven, cam_ack=1), then IDLE.
REQ-023 The read sequence SHALL be: RD_WAIT for WAIT_CYC cycles (ce_a_n=0, oe_n=0, ub/lb=0, dio_a tristated), then RD_CAP for 1 cycle (strobes held; usb_rdata is loaded from dio_a at the end of that cycle), then IDLE with usb_rd_valid=1 in that first IDLE cycle.
REQ-024 Write latency SHALL be WAIT_CYC+2 cycles from the grant edge to cam_ack; read latency SHALL be WAIT_CYC+2 cycles from the grant edge to usb_rd_valid.
REQ-025 A requester that keeps its request high in the cycle after its ack/valid SHALL be treated as making a new request.
REQ-026 dio_a SHALL be driven only in WR_ADDR, WR_PULSE and WR_END, so at least one cycle with dio_a tristated and oe_n=1 always separates a write from a read.
REQ-027 ad SHALL hold its value from the grant until the next grant.
REQ-028 The wait counter SHALL be 4 bits wide; it SHALL be loaded with WAIT_CYC-1 on entry to WR_PULSE/RD_WAIT and count down to 0; it SHALL NOT wrap.
REQ-029 When only one request is present, it SHALL be granted.
REQ-030 When both requests are present, the arbitration policy SHALL be as selected under Configuration.
REQ-031 A request arriving during a busy state SHALL wait; it SHALL NOT be lost and SHALL NOT be acked early.

Reset
REQ-032 While reset_n=0, asynchronously: state=IDLE, ce_a_n=we_n=oe_n=ub_a_n=lb_a_n=1, ad=0, dio_a tristated, cam_ack=0, usb_rd_valid=0, usb_rdata=0, busy=0, last_grant=USB.
REQ-033 A reset asserted mid-access SHALL abort the access immediately and SHALL produce no ack or valid; requesters re-issue their requests after reset.

Configuration
REQ-034 The macro SRAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-035 With SRAM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last (last_grant is updated on each grant), giving strict alternation.
REQ-036 Without SRAM_ARB_RR_EN, the camera SHALL always win simultaneous requests (fixed priority), and last_grant SHALL be absent.

Verification
REQ-037 Single write (WAIT_CYC=2): cam_addr=0x12345, cam_wdata=0xA5A5 -> ad=0x12345, dio_a=0xA5A5, we_n=0 for exactly 2 cycles, cam_ack a single pulse 4 cycles after the grant.
REQ-038 Read-back with an SRAM model: usb_addr=0x12345 after the write of REQ-037 -> usb_rd_valid a single pulse with usb_rdata=0xA5A5, 4 cycles after the grant.
REQ-039 Both requests held continuously for 3 grants -> without the macro: CAM, CAM, CAM (USB starved); with SRAM_ARB_RR_EN: CAM, USB, CAM.
REQ-040 Write immediately followed by a read -> at least 1 cycle with oe_n=1, we_n=1 and dio_a=Z between we_n rising and oe_n falling.
REQ-041 reset_n pulsed low during WR_PULSE -> we_n=1, ce_a_n=1, dio_a=Z in the same timestep, no cam_ack; a re-issued request then completes normally.
